zone_scan_controller: RTL and testbench
=======================================

# zone_scan_controller

Sequences a shared temperature-sample channel across several fire zones and decides per-zone alarm and fault status. A free-running scan tick starts a round-robin request/acknowledge round over all zones. Each returned sample is checked against a threshold with a consecutive-sample confirmation count, and missing acknowledges are counted towards a sensor fault. The block sits between the sensor front-end (one shared sample bus) and the panel outputs: alarm, per-zone status and display.

## Interface
- NUM_ZONES, 4 — zones scanned, 2..8
- SCAN_DIV, 5_000_000 — clk cycles between scan ticks (10 Hz at 50 MHz)
- ACK_TIMEOUT, 255 — cycles in REQ without ack before a miss is declared
- THRESHOLD, 16'd500 — alarm threshold in 0.1 °C; sample >= THRESHOLD counts as hot
- CONFIRM, 3 — consecutive hot samples needed to latch a zone alarm
- FAULT_LIMIT, 3 — consecutive misses needed to flag a zone fault

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- sample_req  out  1  request a sample from zone sample_zone
- sample_zone  out  clog2(NUM_ZONES)  zone being requested
- sample_ack  in  1  sample_data valid; completes the request
- sample_data  in  16  temperature in 0.1 °C, unsigned
- alarm_clear  in  1  single-cycle operator clear
- alarm  out  1  OR of alarm_zones
- alarm_zones  out  NUM_ZONES  latched per-zone alarm
- fault_zones  out  NUM_ZONES  per-zone sensor fault
- display  out  16  last good sample
- display_zone  out  clog2(NUM_ZONES)  zone of display

## Operation
- Reset: all outputs 0; FSM in IDLE; all counters, the pending flag and the tick divider are 0.
- Tick: one-cycle pulse every SCAN_DIV cycles. If the FSM is busy, a tick sets a one-deep pending flag. Further ticks while pending is set are dropped.
- FSM states: IDLE, REQ, EVAL.
  - IDLE → REQ on tick or pending. Zone index = 0; pending cleared.
  - REQ: sample_req = 1 and sample_zone is held stable.
    - If sample_ack = 1: load sample_data into the data register and go to EVAL (hit).
    - If the wait counter = ACK_TIMEOUT − 1 with no ack: go to EVAL (miss).
  - EVAL, one cycle: update the zone being evaluated. Then:
    - If zone index < NUM_ZONES − 1: increment the index and go to REQ.
    - Otherwise go to IDLE.
- sample_ack is ignored outside REQ.
- Hit handling for the zone:
  - Clear its miss counter and fault bit.
  - Set display and display_zone.
  - If the sample is hot, increment the confirm counter, saturating at CONFIRM. When the counter equals CONFIRM, set the alarm_zones bit.
  - If the sample is not hot, clear the confirm counter. The alarm bit stays latched.
- Miss handling for the zone:
  - Increment the miss counter, saturating at FAULT_LIMIT. At FAULT_LIMIT, set the fault bit.
  - The confirm counter and alarm bit are unchanged; display is unchanged.
- alarm_clear: clears every alarm_zones bit whose confirm counter is 0. If EVAL sets the same bit in the same cycle, the set wins.
- Arithmetic: all comparisons are unsigned. Counters are sized clog2(limit + 1) and never wrap.

## Timing
- Tick at cycle t → sample_req = 1 from cycle t + 1.
- Ack sampled high at cycle a:
  - sample_req = 0 from a + 1 (EVAL).
  - display, alarm_zones and fault_zones are updated from a + 2.
  - The next zone's sample_req = 1 from a + 2.
- Miss: sample_req is high for exactly ACK_TIMEOUT cycles, then low for one cycle (EVAL).
- alarm is registered and follows alarm_zones in the same cycle.
- Ack in the first REQ cycle is legal; minimum round = 2·NUM_ZONES cycles.
- Reset asserted mid-round drops sample_req immediately and abandons the round.

## Structure
- Shared package fire_pkg:
  - state enum (IDLE, REQ, EVAL)
  - temperature type (16-bit, 0.1 °C)
  - default THRESHOLD constant
  - zone-index width function
- Sub-module scan_tick_gen: parameterised divider emitting a one-cycle tick every SCAN_DIV cycles, asynchronous reset.
- Per-zone counters are arrays inside zone_scan_controller; no further hierarchy.

## Test plan
- Reset, then SCAN_DIV = 20, all zones ack in 1 cycle with data 300 → four requests per round in zone order 0..3; alarm stays 0; display = 300, display_zone = 3.
- Zone 2 returns 500 for three rounds → alarm_zones = 4'b0100 and alarm = 1 exactly 2 cycles after the third ack. The first two rounds leave alarm = 0; a single 499 in between restarts the count.
- Zone 2 alarmed, alarm_clear while still hot → bit stays set. Zone 2 then returns 200 and alarm_clear is pulsed → bit clears and alarm = 0.
- Zone 1 never acks, ACK_TIMEOUT = 8 → sample_req high 8 cycles per attempt; fault_zones = 4'b0010 after round 3. One good ack clears the fault.
- SCAN_DIV smaller than round length → exactly one pending round follows; surplus ticks are dropped and no request overlaps another.
- Reset asserted while sample_req = 1 and an ack arrives in the same cycle → all outputs 0 and no state change from that ack.

Source files
------------

// File: rtl/fire_pkg.sv
// Shared types and constants for the fire-zone scanning blocks.
package fire_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_EVAL
   } scan_state_e;

   typedef logic [15:0] temp_t;

   localparam temp_t DEFAULT_THRESHOLD = 16'd500;

   function automatic int unsigned zone_idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider: one-cycle tick every SCAN_DIV clock cycles.
module scan_tick_gen #(
   parameter int unsigned SCAN_DIV = 5_000_000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;

   always_comb begin
      cnt_d  = cnt_q + CW'(1);
      tick_d = 1'b0;
      if (cnt_q == CW'(SCAN_DIV - 1)) begin
         cnt_d  = '0;
         tick_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/zone_scan_controller.sv
// Round-robin sample sequencer over fire zones with per-zone alarm
// confirmation and missing-ack fault detection.
module zone_scan_controller
   import fire_pkg::*;
#(
   parameter int unsigned NUM_ZONES   = 4,
   parameter int unsigned SCAN_DIV    = 5_000_000,
   parameter int unsigned ACK_TIMEOUT = 255,
   parameter temp_t       THRESHOLD   = DEFAULT_THRESHOLD,
   parameter int unsigned CONFIRM     = 3,
   parameter int unsigned FAULT_LIMIT = 3
) (
   input  logic                                clk,
   input  logic                                reset,
   output logic                                sample_req,
   output logic [zone_idx_w(NUM_ZONES)-1:0]    sample_zone,
   input  logic                                sample_ack,
   input  logic [15:0]                         sample_data,
   input  logic                                alarm_clear,
   output logic                                alarm,
   output logic [NUM_ZONES-1:0]                alarm_zones,
   output logic [NUM_ZONES-1:0]                fault_zones,
   output logic [15:0]                         display,
   output logic [zone_idx_w(NUM_ZONES)-1:0]    display_zone
);

   localparam int unsigned ZW  = zone_idx_w(NUM_ZONES);
   localparam int unsigned WW  = $clog2(ACK_TIMEOUT + 1);
   localparam int unsigned CFW = $clog2(CONFIRM + 1);
   localparam int unsigned MW  = $clog2(FAULT_LIMIT + 1);

   logic tick;

   scan_tick_gen #(
      .SCAN_DIV (SCAN_DIV)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   scan_state_e          state_q, state_d;
   logic [ZW-1:0]        zone_q, zone_d;
   logic [WW-1:0]        wait_q, wait_d;
   logic                 pending_q, pending_d;
   logic                 hit_q, hit_d;
   temp_t                data_q, data_d;
   logic [CFW-1:0]       conf_q [NUM_ZONES];
   logic [CFW-1:0]       conf_d [NUM_ZONES];
   logic [MW-1:0]        miss_q [NUM_ZONES];
   logic [MW-1:0]        miss_d [NUM_ZONES];
   logic [NUM_ZONES-1:0] alarm_zones_q, alarm_zones_d;
   logic [NUM_ZONES-1:0] fault_zones_q, fault_zones_d;
   temp_t                display_q, display_d;
   logic [ZW-1:0]        display_zone_q, display_zone_d;
   logic                 alarm_q, alarm_d;

   always_comb begin
      state_d        = state_q;
      zone_d         = zone_q;
      wait_d         = wait_q;
      pending_d      = pending_q;
      hit_d          = hit_q;
      data_d         = data_q;
      conf_d         = conf_q;
      miss_d         = miss_q;
      alarm_zones_d  = alarm_zones_q;
      fault_zones_d  = fault_zones_q;
      display_d      = display_q;
      display_zone_d = display_zone_q;

      // Operator clear goes first so a same-cycle EVAL set overrides it.
      for (int unsigned i = 0; i < NUM_ZONES; i++) begin
         if (alarm_clear && (conf_q[i] == '0)) alarm_zones_d[i] = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (tick || pending_q) begin
               state_d   = ST_REQ;
               zone_d    = '0;
               wait_d    = '0;
               pending_d = 1'b0;
            end
         end
         ST_REQ: begin
            pending_d = pending_q | tick;
            if (sample_ack) begin
               data_d  = sample_data;
               hit_d   = 1'b1;
               state_d = ST_EVAL;
            end else if (wait_q == WW'(ACK_TIMEOUT - 1)) begin
               hit_d   = 1'b0;
               state_d = ST_EVAL;
            end else begin
               wait_d = wait_q + WW'(1);
            end
         end
         ST_EVAL: begin
            pending_d = pending_q | tick;
            for (int unsigned i = 0; i < NUM_ZONES; i++) begin
               if (zone_q == ZW'(i)) begin
                  if (hit_q) begin
                     miss_d[i]        = '0;
                     fault_zones_d[i] = 1'b0;
                     display_d        = data_q;
                     display_zone_d   = zone_q;
                     if (data_q >= THRESHOLD) begin
                        if (conf_q[i] != CFW'(CONFIRM)) conf_d[i] = conf_q[i] + CFW'(1);
                        if (conf_d[i] == CFW'(CONFIRM)) alarm_zones_d[i] = 1'b1;
                     end else begin
                        conf_d[i] = '0;
                     end
                  end else begin
                     if (miss_q[i] != MW'(FAULT_LIMIT)) miss_d[i] = miss_q[i] + MW'(1);
                     if (miss_d[i] == MW'(FAULT_LIMIT)) fault_zones_d[i] = 1'b1;
                  end
               end
            end
            if (zone_q < ZW'(NUM_ZONES - 1)) begin
               zone_d  = zone_q + ZW'(1);
               wait_d  = '0;
               state_d = ST_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      alarm_d = |alarm_zones_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         zone_q         <= '0;
         wait_q         <= '0;
         pending_q      <= 1'b0;
         hit_q          <= 1'b0;
         data_q         <= '0;
         conf_q         <= '{default: '0};
         miss_q         <= '{default: '0};
         alarm_zones_q  <= '0;
         fault_zones_q  <= '0;
         display_q      <= '0;
         display_zone_q <= '0;
         alarm_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         zone_q         <= zone_d;
         wait_q         <= wait_d;
         pending_q      <= pending_d;
         hit_q          <= hit_d;
         data_q         <= data_d;
         conf_q         <= conf_d;
         miss_q         <= miss_d;
         alarm_zones_q  <= alarm_zones_d;
         fault_zones_q  <= fault_zones_d;
         display_q      <= display_d;
         display_zone_q <= display_zone_d;
         alarm_q        <= alarm_d;
      end
   end

   assign sample_req   = (state_q == ST_REQ);
   assign sample_zone  = zone_q;
   assign alarm        = alarm_q;
   assign alarm_zones  = alarm_zones_q;
   assign fault_zones  = fault_zones_q;
   assign display      = display_q;
   assign display_zone = display_zone_q;

endmodule

// File: tb/tb_zone_scan_controller.sv
// Randomized round-level bench for zone_scan_controller against a
// transaction-level model of the zone alarm/fault rules and tick schedule.
module tb_zone_scan_controller;
   import fire_pkg::*;

   localparam int NZ  = 4;
   localparam int SD  = 20;
   localparam int AT  = 8;
   localparam int CF  = 3;
   localparam int FL  = 3;
   localparam int THR = 500;

   logic          clk = 1'b0;
   logic          reset;
   logic          sample_req;
   logic [1:0]    sample_zone;
   logic          sample_ack;
   logic [15:0]   sample_data;
   logic          alarm_clear;
   logic          alarm;
   logic [NZ-1:0] alarm_zones;
   logic [NZ-1:0] fault_zones;
   logic [15:0]   display;
   logic [1:0]    display_zone;

   always #5 clk = ~clk;

   zone_scan_controller #(
      .NUM_ZONES   (NZ),
      .SCAN_DIV    (SD),
      .ACK_TIMEOUT (AT),
      .THRESHOLD   (16'd500),
      .CONFIRM     (CF),
      .FAULT_LIMIT (FL)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_req   (sample_req),
      .sample_zone  (sample_zone),
      .sample_ack   (sample_ack),
      .sample_data  (sample_data),
      .alarm_clear  (alarm_clear),
      .alarm        (alarm),
      .alarm_zones  (alarm_zones),
      .fault_zones  (fault_zones),
      .display      (display),
      .display_zone (display_zone)
   );

   // Cycle n is the interval after the n-th rising edge since reset release.
   int cyc;
   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   int errors = 0;
   int checks = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   int m_conf [NZ];
   int m_miss [NZ];
   bit m_alarm[NZ];
   bit m_fault[NZ];
   int m_disp, m_dz;
   int last_s, last_e;

   bit p_miss[NZ];
   int p_dly [NZ];
   int p_dat [NZ];

   function automatic logic [NZ-1:0] m_alarm_vec();
      logic [NZ-1:0] v;
      for (int i = 0; i < NZ; i++) v[i] = m_alarm[i];
      return v;
   endfunction

   function automatic logic [NZ-1:0] m_fault_vec();
      logic [NZ-1:0] v;
      for (int i = 0; i < NZ; i++) v[i] = m_fault[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NZ; i++) begin
         m_conf[i] = 0; m_miss[i] = 0; m_alarm[i] = 0; m_fault[i] = 0;
      end
      m_disp = 0; m_dz = 0; last_s = 0; last_e = 0;
   endtask

   task automatic model_hit(input int z, input int d);
      m_miss[z] = 0; m_fault[z] = 0; m_disp = d; m_dz = z;
      if (d >= THR) begin
         m_conf[z] = (m_conf[z] + 1 > CF) ? CF : m_conf[z] + 1;
         if (m_conf[z] == CF) m_alarm[z] = 1;
      end else begin
         m_conf[z] = 0;
      end
   endtask

   task automatic model_miss(input int z);
      m_miss[z] = (m_miss[z] + 1 > FL) ? FL : m_miss[z] + 1;
      if (m_miss[z] == FL) m_fault[z] = 1;
   endtask

   function automatic int next_tick_ge(input int c);
      int k;
      k = (c + SD - 1) / SD;
      if (k < 1) k = 1;
      return k * SD;
   endfunction

   task automatic check_outputs(input string tag);
      check_eq({tag, "_alarm_zones"}, alarm_zones, m_alarm_vec());
      check_eq({tag, "_alarm"}, alarm, |m_alarm_vec());
      check_eq({tag, "_fault_zones"}, fault_zones, m_fault_vec());
      check_eq({tag, "_display"}, display, m_disp);
      check_eq({tag, "_display_zone"}, display_zone, m_dz);
   endtask

   task automatic plan_all(input int d);
      for (int i = 0; i < NZ; i++) begin
         p_miss[i] = 0; p_dly[i] = 0; p_dat[i] = d;
      end
   endtask

   task automatic plan_random();
      for (int i = 0; i < NZ; i++) begin
         p_miss[i] = ($urandom_range(0, 5) == 0);
         p_dly[i]  = $urandom_range(0, AT - 1);
         p_dat[i]  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535)
                                                 : $urandom_range(THR - 3, THR + 2);
      end
   endtask

   // Called at a falling edge; returns at the falling edge of the first idle cycle.
   task automatic run_round();
      int t, start, waited, hi;
      // A tick anywhere in the previous busy span or its first idle cycle starts the next round at once.
      t = next_tick_ge(last_s);
      start = (t <= last_e) ? last_e + 1 : t + 1;
      waited = 0;
      while (!sample_req && waited < 4 * SD + 60) begin
         @(negedge clk);
         waited++;
      end
      check_eq("req_seen", sample_req, 1'b1);
      if (!sample_req) return;
      check_eq("round_start", cyc, start);
      last_s = cyc;
      for (int z = 0; z < NZ; z++) begin
         check_eq("req_zone", sample_zone, z);
         hi = 1;
         if (p_miss[z]) begin
            for (int k = 1; k < AT; k++) begin
               @(negedge clk);
               if (sample_req && sample_zone == z) hi++;
            end
            check_eq("miss_req_len", hi, AT);
         end else begin
            for (int k = 0; k < p_dly[z]; k++) begin
               @(negedge clk);
               if (sample_req && sample_zone == z) hi++;
            end
            check_eq("req_hold", hi, p_dly[z] + 1);
            sample_ack  = 1'b1;
            sample_data = p_dat[z];
         end
         @(negedge clk);
         sample_ack  = 1'b0;
         sample_data = $urandom_range(0, 65535);
         check_eq("eval_req_low", sample_req, 1'b0);
         check_eq("eval_alarm_hold", alarm_zones, m_alarm_vec());
         if (p_miss[z]) model_miss(z);
         else           model_hit(z, p_dat[z]);
         @(negedge clk);
         check_outputs("upd");
         check_eq(z < NZ - 1 ? "next_req" : "round_end", sample_req, z < NZ - 1);
      end
      last_e = cyc;
   endtask

   task automatic pulse_clear();
      alarm_clear = 1'b1;
      @(negedge clk);
      alarm_clear = 1'b0;
      for (int i = 0; i < NZ; i++) if (m_conf[i] == 0) m_alarm[i] = 0;
      check_eq("clr_alarm_zones", alarm_zones, m_alarm_vec());
      check_eq("clr_alarm", alarm, |m_alarm_vec());
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int waited;
      reset = 1'b1; sample_ack = 1'b0; sample_data = '0; alarm_clear = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_outputs("reset");
      check_eq("reset_req", sample_req, 1'b0);

      // Quiet rounds at 300.
      plan_all(300);
      repeat (2) run_round();

      // Zone 2 hot twice, a single 499 restarts the count, then three hot rounds.
      plan_all(300); p_dat[2] = 500; run_round(); run_round();
      check_eq("z2_no_alarm_yet", alarm, 1'b0);
      p_dat[2] = 499; run_round();
      p_dat[2] = 500; run_round(); run_round();
      check_eq("z2_pre_alarm", alarm, 1'b0);
      run_round();
      check_eq("z2_alarm_zones", alarm_zones, 4'b0100);
      check_eq("z2_alarm", alarm, 1'b1);

      // Clear while hot keeps the bit; after cooling it clears.
      pulse_clear();
      check_eq("z2_kept", alarm_zones, 4'b0100);
      p_dat[2] = 200; run_round();
      pulse_clear();
      check_eq("z2_cleared", alarm_zones, 4'b0000);
      check_eq("z2_alarm_off", alarm, 1'b0);

      // Zone 1 silent for three rounds, then long all-miss rounds exercise the pending tick.
      plan_all(300); p_miss[1] = 1;
      repeat (3) run_round();
      check_eq("z1_fault", fault_zones, 4'b0010);
      for (int i = 0; i < NZ; i++) p_miss[i] = 1;
      repeat (2) run_round();
      plan_all(250); p_dly[3] = AT - 1;
      run_round();
      check_eq("faults_cleared", fault_zones, 4'b0000);

      // Randomized rounds with random operator clears between them.
      for (int r = 0; r < 40; r++) begin
         plan_random();
         run_round();
         if ($urandom_range(0, 2) == 0) pulse_clear();
      end

      // Reset during a request while ack is asserted in the same cycle.
      waited = 0;
      while (!sample_req && waited < 4 * SD + 60) begin
         @(negedge clk);
         waited++;
      end
      check_eq("rst_req_seen", sample_req, 1'b1);
      sample_ack = 1'b1; sample_data = 16'd900; reset = 1'b1;
      #1;
      check_eq("rst_req_drop", sample_req, 1'b0);
      @(negedge clk);
      reset = 1'b0; sample_ack = 1'b0;
      model_reset();
      check_outputs("rst_mid");
      check_eq("rst_mid_req", sample_req, 1'b0);
      plan_all(600);
      run_round();
      check_eq("rst_conf_restart", alarm, 1'b0);
      run_round(); run_round();
      check_eq("rst_alarm_all", alarm_zones, 4'b1111);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
